// File: rtl/pcm_i2s_tx.sv
// rtl/pcm_i2s_tx.sv - stereo I2S transmitter with 1-deep PCM holding buffer
//
// Purpose: captures one signed stereo sample per en_pcm strobe and shifts it
// out as standard I2S (MSB first, one bclk after the lrclk edge). The bit
// clock is derived from clk. Rate mismatches are flagged: overrun when a
// sample is lost, underrun when a frame has to repeat the last sample.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      asynchronous active-low reset
//   en_pcm     1-clk strobe, left/right valid this cycle
//   left       W-bit signed left sample
//   right      W-bit signed right sample
//   i2s_bclk   bit clock, clk/(2*BCLK_DIV), 50% duty
//   i2s_lrclk  word select, 0 = left slot, 1 = right slot
//   i2s_sdata  serial data, updated only on bclk falling edges
//   overrun    1-clk pulse, an unconsumed sample was overwritten
//   underrun   1-clk pulse, frame started without a new sample
module pcm_i2s_tx #(
  parameter int W        = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_pcm,
  input  logic [W-1:0] left,
  input  logic [W-1:0] right,
  output logic         i2s_bclk,
  output logic         i2s_lrclk,
  output logic         i2s_sdata,
  output logic         overrun,
  output logic         underrun
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2 * W);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * W - 1);
  localparam logic [BW-1:0] SLOT_R   = BW'(W);

  logic [DW-1:0]  divcnt;
  logic [BW-1:0]  bitcnt;
  logic [BW-1:0]  bit_next;
  logic [2*W-1:0] shreg;
  logic           pend_valid;
  logic [W-1:0]   pend_l, pend_r;
  logic [W-1:0]   last_l, last_r;
  logic           fall;
  logic           frame_start;
  logic           consume;

  always_comb begin
    // bclk is about to toggle 1->0 on this edge
    fall        = (divcnt == DIV_LAST) && i2s_bclk;
    bit_next    = (bitcnt == BIT_LAST) ? '0 : bitcnt + 1'b1;
    frame_start = fall && (bit_next == '0);
    // holding buffer is emptied into the shifter at frame start
    consume     = frame_start && pend_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divcnt     <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b1;
      i2s_sdata  <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
      bitcnt     <= BIT_LAST;
      shreg      <= '0;
      pend_valid <= 1'b0;
      pend_l     <= '0;
      pend_r     <= '0;
      last_l     <= '0;
      last_r     <= '0;
    end else begin
      overrun  <= en_pcm && pend_valid && !consume;
      underrun <= frame_start && !pend_valid;

      if (divcnt == DIV_LAST) begin
        divcnt   <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        divcnt <= divcnt + 1'b1;
      end

      if (fall) begin
        bitcnt <= bit_next;
        // old MSB goes out before the load/shift, which gives the one-bclk
        // I2S delay: right LSB lands at bit 0 of the following frame
        i2s_sdata <= shreg[2*W-1];
        i2s_lrclk <= (bit_next >= SLOT_R);
        if (frame_start) begin
          if (pend_valid) begin
            shreg  <= {pend_l, pend_r};
            last_l <= pend_l;
            last_r <= pend_r;
          end else begin
            shreg <= {last_l, last_r};
          end
        end else begin
          shreg <= {shreg[2*W-2:0], 1'b0};
        end
      end

      // a new sample wins over the consume clear, so a strobe on the
      // frame-start edge leaves it pending for the next frame
      if (en_pcm) begin
        pend_l     <= left;
        pend_r     <= right;
        pend_valid <= 1'b1;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
